// File: rtl/lsu_stage_if.sv
// Bundles for the three LSU-facing handshakes: EXU->LSU, LSU<->data memory, LSU->WBU.
// Latency: none, wires only.
// Backpressure: carried by ready_out_exu, mem_req_ready and ready_in_wbu.
//
// exu_lsu_if : master = EXU (producer), slave = LSU (consumer)
// lsu_mem_if : master = LSU (requester), slave = data memory
// lsu_wbu_if : master = LSU (producer), slave = WBU (consumer)

interface exu_lsu_if;
    logic        valid_in_exu;
    logic        ready_out_exu;
    logic [2:0]  func3;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] aluOut;
    logic [31:0] wdata;
    logic        gpr_wen;
    logic [4:0]  rd;
    logic [31:0] pc;

    modport master (
        output valid_in_exu, func3, mem_ren, mem_wen, aluOut, wdata, gpr_wen, rd, pc,
        input  ready_out_exu
    );
    modport slave (
        input  valid_in_exu, func3, mem_ren, mem_wen, aluOut, wdata, gpr_wen, rd, pc,
        output ready_out_exu
    );
endinterface

interface lsu_mem_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
    modport slave (
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

interface lsu_wbu_if;
    logic        valid_out_wbu;
    logic        ready_in_wbu;
    logic [31:0] wb_data;
    logic        gpr_wen_buf;
    logic [4:0]  rd_buf;
    logic [31:0] pc_buf;
    logic        lsu_err;

    modport master (
        output valid_out_wbu, wb_data, gpr_wen_buf, rd_buf, pc_buf, lsu_err,
        input  ready_in_wbu
    );
    modport slave (
        input  valid_out_wbu, wb_data, gpr_wen_buf, rd_buf, pc_buf, lsu_err,
        output ready_in_wbu
    );
endinterface

// File: rtl/lsu_stage.sv
// Load/store stage: latches one EXU payload, runs at most one data-memory transaction, holds result for WBU.
// Latency: non-memory/illegal op 1 cycle to valid_out_wbu; memory op minimum 3 cycles.
// Backpressure: accepts only in IDLE; mem_req_ready low stretches REQ, ready_in_wbu low holds DONE.
//
// Ports: clk, rst (async active-low); exu (exu_lsu_if.slave); mem (lsu_mem_if.master);
//        wbu (lsu_wbu_if.master).

module lsu_stage (
    input  logic      clk,
    input  logic      rst,
    exu_lsu_if.slave  exu,
    lsu_mem_if.master mem,
    lsu_wbu_if.master wbu
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state;

    // latched payload
    logic [2:0]  func3_q;
    logic        is_load_q;
    logic [31:0] addr_q;

    // registered outputs
    logic        req_wen_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [3:0]  req_wstrb_q;
    logic [31:0] wb_data_q;
    logic        gpr_wen_q;
    logic [4:0]  rd_q;
    logic [31:0] pc_q;
    logic        err_q;

    // ---------------- acceptance-side decode ----------------
    logic [1:0]  a_lo;
    logic        illegal;
    logic [3:0]  st_strb;
    logic [31:0] st_data;

    assign a_lo = exu.aluOut[1:0];

    always_comb begin
        illegal = 1'b0;
        if (exu.mem_ren && exu.mem_wen) begin
            illegal = 1'b1;
        end else if (exu.mem_ren) begin
            case (exu.func3)
                3'b011, 3'b110, 3'b111: illegal = 1'b1;
                3'b001, 3'b101:         illegal = a_lo[0];
                3'b010:                 illegal = (a_lo != 2'b00);
                default:                illegal = 1'b0;
            endcase
        end else if (exu.mem_wen) begin
            case (exu.func3)
                3'b000:  illegal = 1'b0;
                3'b001:  illegal = a_lo[0];
                3'b010:  illegal = (a_lo != 2'b00);
                default: illegal = 1'b1;
            endcase
        end
    end

    // Store data is replicated across lanes so the strobe alone picks the bytes.
    always_comb begin
        st_strb = 4'b1111;
        st_data = exu.wdata;
        case (exu.func3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << a_lo;
                st_data = {4{exu.wdata[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << a_lo;
                st_data = {2{exu.wdata[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = exu.wdata;
            end
        endcase
    end

    // ---------------- response-side load extraction ----------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_result;

    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = mem.mem_rsp_rdata[7:0];
            2'b01:   ld_byte = mem.mem_rsp_rdata[15:8];
            2'b10:   ld_byte = mem.mem_rsp_rdata[23:16];
            default: ld_byte = mem.mem_rsp_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem.mem_rsp_rdata[31:16] : mem.mem_rsp_rdata[15:0];
        case (func3_q)
            3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_result = {24'd0, ld_byte};
            3'b101:  ld_result = {16'd0, ld_half};
            default: ld_result = mem.mem_rsp_rdata;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            func3_q     <= 3'd0;
            is_load_q   <= 1'b0;
            addr_q      <= 32'd0;
            req_wen_q   <= 1'b0;
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            req_wstrb_q <= 4'd0;
            wb_data_q   <= 32'd0;
            gpr_wen_q   <= 1'b0;
            rd_q        <= 5'd0;
            pc_q        <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (exu.valid_in_exu) begin
                        func3_q   <= exu.func3;
                        is_load_q <= exu.mem_ren;
                        addr_q    <= exu.aluOut;
                        rd_q      <= exu.rd;
                        pc_q      <= exu.pc;
                        if (!exu.mem_ren && !exu.mem_wen) begin
                            wb_data_q <= exu.aluOut;
                            gpr_wen_q <= exu.gpr_wen;
                            err_q     <= 1'b0;
                            state     <= DONE;
                        end else if (illegal) begin
                            // Suppress the register write so a faulting access leaves no trace.
                            wb_data_q <= 32'd0;
                            gpr_wen_q <= 1'b0;
                            err_q     <= 1'b1;
                            state     <= DONE;
                        end else begin
                            gpr_wen_q   <= exu.gpr_wen;
                            err_q       <= 1'b0;
                            req_wen_q   <= exu.mem_wen;
                            req_addr_q  <= {exu.aluOut[31:2], 2'b00};
                            req_wdata_q <= exu.mem_wen ? st_data : 32'd0;
                            req_wstrb_q <= exu.mem_wen ? st_strb : 4'd0;
                            state       <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_req_ready) begin
                        state <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (mem.mem_rsp_valid) begin
                        wb_data_q <= is_load_q ? ld_result : addr_q;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (wbu.ready_in_wbu) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign exu.ready_out_exu = (state == IDLE);

    assign mem.mem_req_valid = (state == REQ);
    assign mem.mem_req_wen   = req_wen_q;
    assign mem.mem_req_addr  = req_addr_q;
    assign mem.mem_req_wdata = req_wdata_q;
    assign mem.mem_req_wstrb = req_wstrb_q;

    assign wbu.valid_out_wbu = (state == DONE);
    assign wbu.wb_data       = wb_data_q;
    assign wbu.gpr_wen_buf   = gpr_wen_q;
    assign wbu.rd_buf        = rd_q;
    assign wbu.pc_buf        = pc_q;
    assign wbu.lsu_err       = err_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: drives EXU/memory/WBU sides by hand and checks against hand-computed values.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at the same point.

module tb_lsu_stage;

    logic clk;
    logic rst;

    exu_lsu_if exu_bus ();
    lsu_mem_if mem_bus ();
    lsu_wbu_if wbu_bus ();

    lsu_stage dut (
        .clk (clk),
        .rst (rst),
        .exu (exu_bus.slave),
        .mem (mem_bus.master),
        .wbu (wbu_bus.master)
    );

    int tests  = 0;
    int failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one EXU payload and hold valid across exactly one edge (LSU must be in IDLE).
    task automatic issue(input logic [2:0] f3, input logic ren, input logic wen,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rdx);
        exu_bus.func3        = f3;
        exu_bus.mem_ren      = ren;
        exu_bus.mem_wen      = wen;
        exu_bus.aluOut       = alu;
        exu_bus.wdata        = wd;
        exu_bus.gpr_wen      = 1'b1;
        exu_bus.rd           = rdx;
        exu_bus.pc           = 32'h0000_1000 + {27'd0, rdx};
        exu_bus.valid_in_exu = 1'b1;
        tick();
        exu_bus.valid_in_exu = 1'b0;
    endtask

    // Load with memory ready immediately and response one cycle later.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        issue(f3, 1'b1, 1'b0, addr, 32'd0, 5'd3);
        check({tag, ".req_vld"},  {31'd0, mem_bus.mem_req_valid}, 32'd1);
        check({tag, ".req_addr"}, mem_bus.mem_req_addr, {addr[31:2], 2'b00});
        check({tag, ".wstrb"},    {28'd0, mem_bus.mem_req_wstrb}, 32'd0);
        tick();
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_rdata = rdata;
        tick();
        mem_bus.mem_rsp_valid = 1'b0;
        check({tag, ".wb_vld"},  {31'd0, wbu_bus.valid_out_wbu}, 32'd1);
        check({tag, ".wb_data"}, wbu_bus.wb_data, exp);
        check({tag, ".err"},     {31'd0, wbu_bus.lsu_err}, 32'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        exu_bus.valid_in_exu  = 1'b0;
        exu_bus.func3         = 3'd0;
        exu_bus.mem_ren       = 1'b0;
        exu_bus.mem_wen       = 1'b0;
        exu_bus.aluOut        = 32'd0;
        exu_bus.wdata         = 32'd0;
        exu_bus.gpr_wen       = 1'b0;
        exu_bus.rd            = 5'd0;
        exu_bus.pc            = 32'd0;
        mem_bus.mem_req_ready = 1'b1;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rsp_rdata = 32'd0;
        wbu_bus.ready_in_wbu  = 1'b1;

        // ---- reset state ----
        #12;
        check("rst.ready_exu", {31'd0, exu_bus.ready_out_exu}, 32'd1);
        check("rst.req_vld",   {31'd0, mem_bus.mem_req_valid}, 32'd0);
        check("rst.req_addr",  mem_bus.mem_req_addr, 32'd0);
        check("rst.wstrb",     {28'd0, mem_bus.mem_req_wstrb}, 32'd0);
        check("rst.wb_vld",    {31'd0, wbu_bus.valid_out_wbu}, 32'd0);
        check("rst.wb_data",   wbu_bus.wb_data, 32'd0);
        check("rst.err",       {31'd0, wbu_bus.lsu_err}, 32'd0);
        rst = 1'b1;
        tick();

        // ---- non-memory pass-through ----
        check("nm.ready_exu", {31'd0, exu_bus.ready_out_exu}, 32'd1);
        issue(3'd0, 1'b0, 1'b0, 32'h1234_5678, 32'd0, 5'd5);
        check("nm.wb_vld",  {31'd0, wbu_bus.valid_out_wbu}, 32'd1);
        check("nm.wb_data", wbu_bus.wb_data, 32'h1234_5678);
        check("nm.rd_buf",  {27'd0, wbu_bus.rd_buf}, 32'd5);
        check("nm.gpr_wen", {31'd0, wbu_bus.gpr_wen_buf}, 32'd1);
        check("nm.pc_buf",  wbu_bus.pc_buf, 32'h0000_1005);
        check("nm.req_vld", {31'd0, mem_bus.mem_req_valid}, 32'd0);
        check("nm.ready0",  {31'd0, exu_bus.ready_out_exu}, 32'd0);
        tick();
        check("nm.idle_vld", {31'd0, wbu_bus.valid_out_wbu}, 32'd0);
        check("nm.idle_rdy", {31'd0, exu_bus.ready_out_exu}, 32'd1);

        // ---- loads ----
        do_load("lb",  3'b000, 32'h8000_0003, 32'h80FF_0011, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h8000_0003, 32'h80FF_0011, 32'h0000_0080);
        do_load("lh",  3'b001, 32'h0000_0002, 32'h8001_1234, 32'hFFFF_8001);
        do_load("lhu", 3'b101, 32'h0000_0000, 32'h8001_9234, 32'h0000_9234);

        // ---- SH with 3 cycles of request stall ----
        mem_bus.mem_req_ready = 1'b0;
        issue(3'b001, 1'b0, 1'b1, 32'h0000_0102, 32'hAAAA_BEEF, 5'd0);
        for (int i = 0; i < 4; i++) begin
            check("sh.req_vld",   {31'd0, mem_bus.mem_req_valid}, 32'd1);
            check("sh.req_wen",   {31'd0, mem_bus.mem_req_wen}, 32'd1);
            check("sh.req_addr",  mem_bus.mem_req_addr, 32'h0000_0100);
            check("sh.wstrb",     {28'd0, mem_bus.mem_req_wstrb}, 32'h0000_000C);
            check("sh.req_wdata", mem_bus.mem_req_wdata, 32'hBEEF_BEEF);
            if (i == 3) mem_bus.mem_req_ready = 1'b1;
            tick();
        end
        check("sh.req_drop", {31'd0, mem_bus.mem_req_valid}, 32'd0);
        mem_bus.mem_rsp_valid = 1'b1;
        tick();
        mem_bus.mem_rsp_valid = 1'b0;
        check("sh.wb_vld",  {31'd0, wbu_bus.valid_out_wbu}, 32'd1);
        check("sh.wb_data", wbu_bus.wb_data, 32'h0000_0102);
        tick();

        // ---- SB at byte 1 ----
        issue(3'b000, 1'b0, 1'b1, 32'h0000_0201, 32'h1234_56AB, 5'd0);
        check("sb.wstrb",     {28'd0, mem_bus.mem_req_wstrb}, 32'h0000_0002);
        check("sb.req_wdata", mem_bus.mem_req_wdata, 32'hABAB_ABAB);
        check("sb.req_addr",  mem_bus.mem_req_addr, 32'h0000_0200);
        tick();
        mem_bus.mem_rsp_valid = 1'b1;
        tick();
        mem_bus.mem_rsp_valid = 1'b0;
        check("sb.wb_vld", {31'd0, wbu_bus.valid_out_wbu}, 32'd1);
        tick();

        // ---- misaligned LW ----
        issue(3'b010, 1'b1, 1'b0, 32'h0000_0101, 32'd0, 5'd9);
        check("mis.wb_vld",  {31'd0, wbu_bus.valid_out_wbu}, 32'd1);
        check("mis.err",     {31'd0, wbu_bus.lsu_err}, 32'd1);
        check("mis.gpr_wen", {31'd0, wbu_bus.gpr_wen_buf}, 32'd0);
        check("mis.wb_data", wbu_bus.wb_data, 32'd0);
        check("mis.req_vld", {31'd0, mem_bus.mem_req_valid}, 32'd0);
        tick();

        // ---- illegal store func3 ----
        issue(3'b011, 1'b0, 1'b1, 32'h0000_0200, 32'd0, 5'd1);
        check("ilst.err",     {31'd0, wbu_bus.lsu_err}, 32'd1);
        check("ilst.req_vld", {31'd0, mem_bus.mem_req_valid}, 32'd0);
        tick();

        // ---- WBU backpressure during a load ----
        wbu_bus.ready_in_wbu = 1'b0;
        issue(3'b010, 1'b1, 1'b0, 32'h0000_0200, 32'd0, 5'd2);
        tick();
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_rdata = 32'hCAFE_F00D;
        tick();
        mem_bus.mem_rsp_valid = 1'b0;
        exu_bus.func3        = 3'd0;
        exu_bus.mem_ren      = 1'b0;
        exu_bus.mem_wen      = 1'b0;
        exu_bus.aluOut       = 32'h0000_DEAD;
        exu_bus.rd           = 5'd7;
        exu_bus.gpr_wen      = 1'b1;
        exu_bus.valid_in_exu = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp.wb_vld",    {31'd0, wbu_bus.valid_out_wbu}, 32'd1);
            check("bp.wb_data",   wbu_bus.wb_data, 32'hCAFE_F00D);
            check("bp.ready_exu", {31'd0, exu_bus.ready_out_exu}, 32'd0);
            tick();
        end
        wbu_bus.ready_in_wbu = 1'b1;
        tick();
        check("bp.k_vld",  {31'd0, wbu_bus.valid_out_wbu}, 32'd0);
        check("bp.k_rdy",  {31'd0, exu_bus.ready_out_exu}, 32'd1);
        check("bp.k_data", wbu_bus.wb_data, 32'hCAFE_F00D);
        tick();
        exu_bus.valid_in_exu = 1'b0;
        check("bp.k1_vld",  {31'd0, wbu_bus.valid_out_wbu}, 32'd1);
        check("bp.k1_data", wbu_bus.wb_data, 32'h0000_DEAD);
        check("bp.k1_rd",   {27'd0, wbu_bus.rd_buf}, 32'd7);
        tick();

        // ---- reset during WAIT_RSP ----
        issue(3'b010, 1'b1, 1'b0, 32'h0000_0300, 32'd0, 5'd4);
        check("rw.req_vld", {31'd0, mem_bus.mem_req_valid}, 32'd1);
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("rw.ready_exu", {31'd0, exu_bus.ready_out_exu}, 32'd1);
        check("rw.req_vld0",  {31'd0, mem_bus.mem_req_valid}, 32'd0);
        check("rw.req_addr",  mem_bus.mem_req_addr, 32'd0);
        check("rw.wb_data",   wbu_bus.wb_data, 32'd0);
        check("rw.rd_buf",    {27'd0, wbu_bus.rd_buf}, 32'd0);
        check("rw.pc_buf",    wbu_bus.pc_buf, 32'd0);
        check("rw.wb_vld",    {31'd0, wbu_bus.valid_out_wbu}, 32'd0);
        #2;
        rst = 1'b1;
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_rdata = 32'h0000_0055;
        tick();
        mem_bus.mem_rsp_valid = 1'b0;
        check("rw.late_vld",  {31'd0, wbu_bus.valid_out_wbu}, 32'd0);
        check("rw.late_rdy",  {31'd0, exu_bus.ready_out_exu}, 32'd1);
        check("rw.late_data", wbu_bus.wb_data, 32'd0);
        tick();
        check("rw.late_vld2", {31'd0, wbu_bus.valid_out_wbu}, 32'd0);
        check("rw.late_req",  {31'd0, mem_bus.mem_req_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
# lsu_stage

Load/store stage of the multi-cycle NPC core: it is the consumer end of the EXU→LSU valid/ready handshake and the producer end of LSU→WBU. It latches one instruction's memory-side payload from EXU and, for loads and stores, runs one transaction on a simple request/response data-memory port, with byte-lane alignment, store strobes and load sign/zero extension. It then holds the writeback result until WBU accepts it. Non-memory instructions pass straight through with one cycle of buffering.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- valid_in_exu  in  1  EXU payload valid
- ready_out_exu  out  1  LSU can accept (high only in IDLE)
- func3  in  3  load/store size/sign code (RV32I)
- mem_ren / mem_wen  in  1 each  load / store; both 0 = non-memory op; both 1 is illegal
- aluOut  in  32  effective address, or result for non-memory ops
- wdata  in  32  store data (rs2)
- gpr_wen  in  1;  rd  in  5;  pc  in  32  passed to WBU
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_wen  out  1  1 = write
- mem_req_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_req_wdata  out  32  lane-shifted store data
- mem_req_wstrb  out  4  byte strobes (0 for reads)
- mem_rsp_valid  in  1  response / write-ack valid (one cycle)
- mem_rsp_rdata  in  32  read word
- valid_out_wbu  out  1  result valid (high only in DONE)
- ready_in_wbu  in  1  WBU accepts
- wb_data  out  32  load result or passed aluOut
- gpr_wen_buf, rd_buf, pc_buf  out  1/5/32  latched pass-through
- lsu_err  out  1  misaligned or illegal access, valid with valid_out_wbu

## Operation
- States: IDLE, REQ, WAIT_RSP, DONE (2-bit state register).
- IDLE: ready_out_exu=1. On valid_in_exu, latch all payload. Next state:
  - REQ, if it is a memory op and legal.
  - DONE with wb_data=aluOut and lsu_err=0, if it is a non-memory op.
  - DONE with lsu_err=1, wb_data=0 and gpr_wen_buf forced to 0, if it is illegal.
- Illegal access, determined from addr[1:0]:
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - load func3 ∈ {011,110,111};
  - store func3 ∉ {000,001,010};
  - mem_ren=mem_wen=1.
  An illegal access issues no memory request.
- REQ: mem_req_valid=1, with all mem_req_* fields stable. When mem_req_ready=1, go to WAIT_RSP.
- WAIT_RSP: wait for mem_rsp_valid.
  - Load: extract by addr[1:0]. LB/LBU use byte addr[1:0]; LH/LHU use half addr[1]. LB/LH sign-extend, LBU/LHU/LW zero-extend or pass. Latch the result into wb_data.
  - Store: the response is an ack; wb_data=aluOut.
  - In both cases go to DONE.
- Store lanes:
  - SB: strobe 4'b0001<<addr[1:0], data = {4{wdata[7:0]}}.
  - SH: strobe 4'b0011<<addr[1:0], data = {2{wdata[15:0]}}.
  - SW: strobe 4'b1111, data = wdata.
- DONE: valid_out_wbu=1; outputs held stable. When ready_in_wbu=1, go to IDLE.
- mem_rsp_valid outside WAIT_RSP is ignored. valid_in_exu outside IDLE is ignored, because ready_out_exu=0 there.

## Timing
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0 except ready_out_exu=1. This includes wb_data, *_buf, lsu_err and mem_req_*.
- Reset asserted mid-transaction abandons it; no request or WBU valid survives. The response to an abandoned request, if it arrives after reset, is ignored.
- Handshakes: a transfer occurs on the rising edge where valid and ready are both 1. valid never depends combinationally on ready.
- Latency, with acceptance edge = cycle 0:
  - Non-memory op: valid_out_wbu in cycle 1.
  - Memory op: mem_req_valid in cycle 1. With ready in cycle 1 and the response in cycle 2, valid_out_wbu is in cycle 3 (minimum).
- Back-to-back: after DONE→IDLE at edge k, the next acceptance is possible at edge k+1. Throughput is at most 1 instruction per 2 cycles.
- mem_req_ready low for N cycles extends REQ by N cycles. ready_in_wbu low holds DONE indefinitely.

## Test plan
- Non-memory pass-through: aluOut=0x1234_5678, gpr_wen=1, rd=5, WBU ready. Required: valid_out_wbu 1 cycle after acceptance, wb_data=0x12345678, rd_buf=5, and no mem_req_valid.
- LB sign extension: addr=0x8000_0003, rdata=0x80FF_0011. Required: req addr=0x8000_0000, wstrb=0, wb_data=0xFFFF_FF80. With LBU, wb_data=0x0000_0080.
- SH at addr=0x102, wdata=0xAAAA_BEEF, mem_req_ready low for 3 cycles. Required: mem_req_valid held 4 cycles with fields stable, wstrb=4'b1100, mem_req_wdata=0xBEEF_BEEF.
- Misaligned LW at addr 0x101. Required: no mem_req_valid, DONE in cycle 1, lsu_err=1, gpr_wen_buf=0, wb_data=0.
- WBU backpressure: ready_in_wbu low for 5 cycles during a load. Required: wb_data and valid_out_wbu held, ready_out_exu=0 throughout, and a new EXU valid is not accepted until the cycle after the WBU handshake.
- Reset during WAIT_RSP: drive rst=0 asynchronously, then a late mem_rsp_valid. Required: outputs go to reset values immediately, state=IDLE, the response is ignored, and no valid_out_wbu is asserted.
